// File: rtl/mem_arbiter_if.sv
// Signal bundle between three memory requesters, the arbiter and a single-port RAM.
// Latency: none, wires only.
// Backpressure: none here; requesters hold req until ack, and hold stalls new grants.
// Ports: master = requesters + RAM model (req/we/addr/wdata/hold/ram_rdata),
//        slave  = arbiter (gnt/ack/rdata/busy and the ram_* access bus).
interface mem_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [23:0] addr;
  logic [23:0] wdata;
  logic        hold;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  modport master (
    output req, we, addr, wdata, hold, ram_rdata,
    input  gnt, ack, rdata, busy, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req, we, addr, wdata, hold, ram_rdata,
    output gnt, ack, rdata, busy, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving three requesters (loader, fetch, data) turns on one RAM.
// Latency: grant edge N -> LATENCY access cycles -> ack in the cycle after, then one IDLE cycle.
// Backpressure: hold blocks new grants only; a requester holds req until its ack.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries req/we/addr/wdata/hold in,
//        gnt/ack/rdata/busy out, and the ram_en/ram_we/ram_addr/ram_wdata/ram_rdata RAM bus.
module mem_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [1:0]  last_q;

  logic [1:0]  cand1, cand2, win_idx;
  logic        take;
  logic        capture;
  logic        state_ok;
  logic [2:0]  owner_oh;

  logic [2:0]  gnt_c, ack_c;
  logic        busy_c, ram_en_c, ram_we_c;
  logic [7:0]  ram_addr_c, ram_wdata_c;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Priority order is last+1, last+2, then last itself.
  always_comb begin
    cand1 = rr_next(last_q);
    cand2 = rr_next(cand1);
    if (bus.req[cand1]) begin
      win_idx = cand1;
    end else if (bus.req[cand2]) begin
      win_idx = cand2;
    end else begin
      win_idx = (last_q == 2'd3) ? 2'd2 : last_q;
    end
  end

  assign state_ok = (state_q == IDLE) || (state_q == ACCESS) || (state_q == DONE);
  assign owner_oh = 3'b001 << idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= win_idx;
        we_q    <= bus.we[win_idx];
        addr_q  <= bus.addr[{win_idx, 3'b000} +: 8];
        wdata_q <= bus.wdata[{win_idx, 3'b000} +: 8];
        last_q  <= win_idx;
      end
      if (capture) begin
        rdata_q <= bus.ram_rdata;
      end else if (!state_ok) begin
        rdata_q <= 8'd0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    take        = 1'b0;
    capture     = 1'b0;
    gnt_c       = 3'b000;
    ack_c       = 3'b000;
    busy_c      = 1'b0;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = 8'd0;
    ram_wdata_c = 8'd0;
    case (state_q)
      IDLE: begin
        if (!bus.hold && (bus.req != 3'b000)) begin
          take    = 1'b1;
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy_c      = 1'b1;
        gnt_c       = owner_oh;
        ram_en_c    = 1'b1;
        ram_we_c    = we_q;
        ram_addr_c  = addr_q;
        ram_wdata_c = wdata_q;
        if (cnt_q == LAST_CNT) begin
          // RAM read data is valid in this final access cycle.
          capture = !we_q;
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        busy_c  = 1'b1;
        gnt_c   = owner_oh;
        ack_c   = owner_oh;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_c;
  assign bus.ack       = ack_c;
  assign bus.busy      = busy_c;
  assign bus.ram_en    = ram_en_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.rdata     = state_ok ? rdata_q : 8'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic,
// all outputs compared every cycle against a transaction-timeline reference model.
// Stimulus is driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model
  logic [7:0] ram_mem [256];
  assign bus.ram_rdata = ram_mem[bus.ram_addr];

  // Reference model: age = cycles since grant (0 = idle)
  int         m_age;
  int         m_idx;
  int         m_last;
  logic       m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic [7:0] ref_mem [256];

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] ack_seq [$];
  int         ack_cyc [$];
  bit         pending [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  c;
    bit  found;
    if (rst) begin
      m_age   = 0;
      m_last  = 2;
      m_rdata = 8'h00;
    end else if (m_age == 0) begin
      if (!bus.hold && bus.req != 3'b000) begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (!found && bus.req[c]) begin
            found = 1'b1;
            m_idx = c;
          end
        end
        m_last  = m_idx;
        m_we    = bus.we[m_idx];
        m_addr  = bus.addr[8*m_idx +: 8];
        m_wdata = bus.wdata[8*m_idx +: 8];
        if (m_we) ref_mem[m_addr] = m_wdata;
        m_age = 1;
      end
    end else if (m_age >= LAT + 1) begin
      m_age = 0;
    end else begin
      m_age++;
      if (m_age == LAT + 1 && !m_we) m_rdata = ref_mem[m_addr];
    end
  endtask

  task automatic check_outputs();
    logic [2:0] oh;
    logic       e_en;
    oh   = (m_age != 0) ? 3'(1 << m_idx) : 3'b000;
    e_en = (m_age >= 1) && (m_age <= LAT);
    chk("gnt", bus.gnt, oh);
    chk("ack", bus.ack, (m_age == LAT + 1) ? oh : 3'b000);
    chk("busy/ram_en/ram_we", {bus.busy, bus.ram_en, bus.ram_we},
        {m_age != 0, e_en, e_en && m_we});
    if (e_en) begin
      chk("ram_addr", bus.ram_addr, m_addr);
      chk("ram_wdata", bus.ram_wdata, m_wdata);
    end
    chk("rdata", bus.rdata, m_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1) ram_mem[bus.ram_addr] = bus.ram_wdata;
    check_outputs();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic run_until_ack(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (bus.ack == 3'b000 && cyc < max_cyc);
  endtask

  task automatic collect_acks(input int n, input bit drop);
    int guard;
    guard = 0;
    ack_seq.delete();
    ack_cyc.delete();
    while (ack_seq.size() < n && guard < 100) begin
      step();
      guard++;
      if (bus.ack != 3'b000) begin
        ack_seq.push_back(bus.ack);
        ack_cyc.push_back(guard);
        if (drop) bus.req = bus.req & ~bus.ack;
      end
    end
    chk("ack_count", ack_seq.size(), n);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    logic [2:0] exp_rr [6];
    logic [2:0] exp_fair [4];
    logic [7:0] v;

    bus.req   = 3'b000;
    bus.we    = 3'b000;
    bus.addr  = 24'h0;
    bus.wdata = 24'h0;
    bus.hold  = 1'b0;
    rst       = 1'b1;
    m_age = 0; m_idx = 0; m_last = 2; m_we = 1'b0;
    m_addr = 8'h0; m_wdata = 8'h0; m_rdata = 8'h0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    ram_mem[8'h3C] = 8'hA5;
    ref_mem[8'h3C] = 8'hA5;

    // Reset state
    step();
    step();
    chk("rst_ram_addr", bus.ram_addr, 8'h00);
    chk("rst_ram_wdata", bus.ram_wdata, 8'h00);
    chk("rst_rdata", bus.rdata, 8'h00);
    rst = 1'b0;
    step();
    chk("idle_no_req_gnt", bus.gnt, 3'b000);

    // Single read from loader
    bus.req = 3'b001;
    bus.addr = 24'h00003C;
    step();
    chk("rd_gnt", bus.gnt, 3'b001);
    chk("rd_ram_addr", bus.ram_addr, 8'h3C);
    run_until_ack(20, cyc);
    chk("rd_latency", cyc + 1, LAT + 1);
    chk("rd_ack", bus.ack, 3'b001);
    chk("rd_data", bus.rdata, 8'hA5);
    bus.req = 3'b000;
    step();

    // Single write from data port, then fetch port reads it back
    bus.req = 3'b100;
    bus.we = 3'b100;
    bus.addr = 24'h100000;
    bus.wdata = 24'h7E0000;
    run_until_ack(20, cyc);
    chk("wr_latency", cyc, LAT + 1);
    chk("wr_ack", bus.ack, 3'b100);
    chk("wr_ram_we_done", bus.ram_we, 1'b0);
    chk("wr_memory", ram_mem[8'h10], 8'h7E);
    chk("wr_rdata_kept", bus.rdata, 8'hA5);
    bus.req = 3'b000;
    bus.we = 3'b000;
    step();
    bus.req = 3'b010;
    bus.addr = 24'h001000;
    run_until_ack(20, cyc);
    chk("rb_data", bus.rdata, 8'h7E);
    bus.req = 3'b000;
    step();

    // Contention: order 0,1,2 twice after reset
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    reset_pulse();
    bus.req = 3'b111;
    collect_acks(3, 1'b1);
    for (int i = 0; i < ack_seq.size(); i++) chk("rr_order_a", ack_seq[i], exp_rr[i]);
    bus.req = 3'b111;
    collect_acks(3, 1'b1);
    for (int i = 0; i < ack_seq.size(); i++) chk("rr_order_b", ack_seq[i], exp_rr[i+3]);
    step();

    // Fairness with two continuous requesters
    exp_fair = '{3'b001, 3'b010, 3'b001, 3'b010};
    reset_pulse();
    bus.req = 3'b011;
    collect_acks(4, 1'b0);
    bus.req = 3'b000;
    for (int i = 0; i < ack_seq.size(); i++) chk("fair_order", ack_seq[i], exp_fair[i]);
    for (int i = 1; i < ack_cyc.size(); i++) chk("fair_spacing", ack_cyc[i] - ack_cyc[i-1], LAT + 2);
    step();
    step();

    // Hold blocks grants
    bus.hold = 1'b1;
    bus.req = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_no_gnt", bus.gnt, 3'b000);
    end
    bus.hold = 1'b0;
    step();
    chk("hold_release_gnt", bus.gnt, 3'b010);
    run_until_ack(20, cyc);
    chk("hold_ack_latency", cyc, LAT);
    bus.req = 3'b000;
    step();

    // Reset mid-access
    reset_pulse();
    bus.req = 3'b010;
    step();
    chk("mid_gnt_before", bus.gnt, 3'b010);
    rst = 1'b1;
    step();
    chk("mid_gnt_after", bus.gnt, 3'b000);
    chk("mid_ram_en_after", bus.ram_en, 1'b0);
    chk("mid_ack_after", bus.ack, 3'b000);
    rst = 1'b0;
    bus.req = 3'b011;
    step();
    chk("mid_next_gnt", bus.gnt, 3'b001);
    bus.req = 3'b000;
    for (int i = 0; i < LAT + 2; i++) step();

    // Randomized traffic
    for (int i = 0; i < 3; i++) pending[i] = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.hold = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 3; i++) begin
        if (pending[i] && m_age == LAT + 1 && m_idx == i) pending[i] = 1'b0;
        else if (!pending[i] && $urandom_range(0, 2) == 0) pending[i] = 1'b1;
      end
      bus.req = {pending[2], pending[1], pending[0]};
      bus.we = 3'($urandom);
      bus.addr = {4'h0, 4'($urandom), 4'h0, 4'($urandom), 4'h0, 4'($urandom)};
      bus.wdata = 24'($urandom);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, giving RAM access cycles per transaction (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 The block SHALL have port req, input, 3, per-requester request (bit0 loader, bit1 fetch, bit2 data).
REQ-005 The block SHALL have port we, input, 3, per-requester write enable, sampled with req.
REQ-006 The block SHALL have port addr, input, 24, three packed 8-bit addresses, requester i at bits [8i+7:8i].
REQ-007 The block SHALL have port wdata, input, 24, three packed 8-bit write data, same packing as addr.
REQ-008 The block SHALL have port hold, input, 1, when high no new grant is issued.
REQ-009 The block SHALL have port gnt, output, 3, one-hot grant of the requester currently owning the RAM.
REQ-010 The block SHALL have port ack, output, 3, one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port rdata, output, 8, registered read data, valid while ack is high.
REQ-012 The block SHALL have port ram_en, output, 1, RAM access enable.
REQ-013 The block SHALL have port ram_we, output, 1, RAM write strobe.
REQ-014 The block SHALL have port ram_addr, output, 8, RAM address.
REQ-015 The block SHALL have port ram_wdata, output, 8, RAM write data.
REQ-016 The block SHALL have port ram_rdata, input, 8, RAM read data, valid in the last ACCESS cycle.
REQ-017 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-019 IDLE, hold low, req nonzero: select one requester by round-robin, order last+1, last+2, last (mod 3); go to ACCESS.
REQ-020 On that IDLE edge: latch winner index, we bit, addr byte and wdata byte into internal registers; set gnt one-hot.
REQ-021 IDLE with hold high or req zero SHALL stay in IDLE, no output change.
REQ-022 ACCESS SHALL last exactly LATENCY cycles, counted by a 4-bit counter cleared on entry.
REQ-023 During ACCESS: ram_en=1, ram_addr/ram_we/ram_wdata from latched values; outputs held constant throughout.
REQ-024 Last ACCESS cycle: register ram_rdata into rdata for reads; for writes rdata keeps its prior value.
REQ-025 DONE SHALL last one cycle: ack[g]=1, ram_en=0, ram_we=0, gnt still asserted; next state IDLE.
REQ-026 Latency: req sampled in IDLE at edge N gives ack high in cycle N+LATENCY+1; default LATENCY=2 gives 3.
REQ-027 Back-to-back: minimum one IDLE cycle between DONE and the next ACCESS; throughput one transaction per LATENCY+2 cycles.
REQ-028 The last-grant pointer SHALL update on each grant; a lone requester wins every time.
REQ-029 Requester i SHALL be required to hold req[i] high until ack[i]; req sampled only in IDLE.
REQ-030 Deassertion of req or changes to addr/wdata/we during ACCESS or DONE SHALL NOT abort or alter the transaction.
REQ-031 hold asserted during ACCESS or DONE SHALL NOT affect the transaction in flight; it only blocks the next grant.
REQ-032 gnt SHALL be all-zero in IDLE; ack SHALL be all-zero outside DONE; at most one bit of each high.
REQ-033 Illegal state encodings SHALL go to IDLE next cycle with all outputs at reset values.

Reset
REQ-034 rst high at a clock edge SHALL force state IDLE, counter 0, gnt=0, ack=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0, busy=0.
REQ-035 On reset the last-grant pointer SHALL be 2, so the first arbitration favours requester 0.
REQ-036 rst during ACCESS SHALL abort the transaction with no ack; ram_en drops the next cycle; reset also applies in cycles before the first clock edge is not relied on.

Verification
REQ-037 Single read: req=001, addr[7:0]=0x3C, ram_rdata=0xA5 -> gnt=001, ram_addr=0x3C for 2 cycles, ack=001 at cycle 3, rdata=0xA5.
REQ-038 Single write: req=100, we=100, addr[23:16]=0x10, wdata[23:16]=0x7E -> ram_we=1, ram_wdata=0x7E for 2 cycles, ack=100, ram_we=0 in DONE.
REQ-039 Contention: req=111 held after reset, each dropped one cycle after its ack -> grant order 0,1,2; re-assert all -> 0,1,2 again.
REQ-040 Fairness: req=011 held continuously -> grants alternate 0,1,0,1; each ack spaced LATENCY+2=4 cycles apart.
REQ-041 Hold: hold=1 with req=010 -> no gnt for 5 cycles; hold=0 -> gnt=010 next cycle, ack 3 cycles later.
REQ-042 Reset mid-access: rst pulse in first ACCESS cycle -> no ack, gnt=000, ram_en=0 next cycle; next grant goes to requester 0.
